// File: rtl/key_event_gen.sv
// key_event_gen: 5-key press / auto-repeat event queue; auto-repeat present only with KEY_EVENT_AUTOREPEAT_EN.
// Latency: a press sampled on edge N is pushed on edge N+1 and presented right after it.
// Backpressure: 4-entry FIFO; presses wait in pend, repeats that cannot be pushed are dropped (sticky overflow).
module key_event_gen #(
  parameter logic [23:0] HOLD_CYCLES   = 24'd9_500_000,
  parameter logic [23:0] REPEAT_CYCLES = 24'd3_800_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] db_in,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       evt_repeat,
  output logic [4:0] held,
  output logic       overflow
);

  localparam int DEPTH = 4;

  logic [4:0] held_q;
  logic       prime_q;
  logic [4:0] pend_q, pend_d;
  logic [4:0] press;
  logic [4:0] pend_clr;
  logic [3:0] mem_q [DEPTH];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       full, pop, push_vld, pend_any;
  logic       rpt_req, rpt_drop;
  logic [2:0] pend_idx, rpt_key;
  logic [3:0] push_dat, head;

  // prime_q masks press detection on the first edge after reset, so keys held
  // through reset only reload held instead of producing a press.
  assign press    = prime_q ? 5'd0 : (db_in & ~held_q);
  assign pend_any = |pend_q;
  assign full     = (count_q == 3'd4);
  assign pop      = evt_valid & evt_ready;

  always_comb begin
    pend_idx = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      if (pend_q[k]) pend_idx = 3'(k);
    end
  end

  always_comb begin
    push_vld = 1'b0;
    push_dat = 4'd0;
    pend_clr = 5'd0;
    if (!full) begin
      if (pend_any) begin
        push_vld = 1'b1;
        push_dat = {1'b0, pend_idx};
        pend_clr = 5'b00001 << pend_idx;
      end else if (rpt_req) begin
        push_vld = 1'b1;
        push_dat = {1'b1, rpt_key};
      end
    end
  end

  assign rpt_drop   = rpt_req & (full | pend_any);
  assign pend_d     = (pend_q & ~pend_clr) | press;
  assign count_d    = count_q + {2'b00, push_vld} - {2'b00, pop};
  assign overflow_d = (overflow_q & ~ovf_clr) | rpt_drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= 5'd0;
      prime_q    <= 1'b1;
      pend_q     <= 5'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      count_q    <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      held_q     <= db_in;
      prime_q    <= 1'b0;
      pend_q     <= pend_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push_vld) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 2'd1;
    end
  end

  // Storage needs no reset: entries are only visible while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push_vld && !reset) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head       = mem_q[rd_ptr_q];
  assign evt_valid  = (count_q != 3'd0);
  assign evt_code   = evt_valid ? head[2:0] : 3'd0;
  assign evt_repeat = evt_valid & head[3];
  assign held       = held_q;
  assign overflow   = overflow_q;

`ifdef KEY_EVENT_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rstate_t;

  rstate_t     state_q, state_d;
  logic [23:0] rcnt_q, rcnt_d;
  logic [2:0]  rkey_q, rkey_d;
  logic [2:0]  db_idx;
  logic        db_onehot, db_chg;

  assign db_onehot = (db_in != 5'd0) && ((db_in & (db_in - 5'd1)) == 5'd0);
  assign db_chg    = (db_in != held_q);

  always_comb begin
    db_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (db_in[k]) db_idx = 3'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rkey_d  = rkey_q;
    rpt_req = 1'b0;
    case (state_q)
      DELAY: begin
        if (db_chg) begin
          state_d = IDLE;
        end else if (rcnt_q == HOLD_CYCLES - 24'd1) begin
          rpt_req = 1'b1;
          state_d = RPT;
          rcnt_d  = 24'd0;
        end else begin
          rcnt_d = rcnt_q + 24'd1;
        end
      end
      RPT: begin
        if (db_chg) begin
          state_d = IDLE;
        end else if (rcnt_q == REPEAT_CYCLES - 24'd1) begin
          rpt_req = 1'b1;
          rcnt_d  = 24'd0;
        end else begin
          rcnt_d = rcnt_q + 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A key change that drops back to IDLE may re-arm on the same edge.
    if (state_d == IDLE && (|press) && db_onehot) begin
      state_d = DELAY;
      rkey_d  = db_idx;
      rcnt_d  = 24'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q  <= 24'd0;
      rkey_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rkey_q  <= rkey_d;
    end
  end

  assign rpt_key = rkey_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_CYCLES, REPEAT_CYCLES};
  assign rpt_req    = 1'b0;
  assign rpt_key    = 3'd0;
`endif

endmodule
